// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI target peripheral.
package spi_pkg;

   localparam int unsigned RegAddrW = 12;
   localparam int unsigned BusDataW = 32;
   localparam int unsigned ByteW    = 8;
   localparam int unsigned BitCntW  = 3;

   // Register offsets inside the 4 KiB window
   localparam logic [RegAddrW-1:0] RegRxData = 12'h000;
   localparam logic [RegAddrW-1:0] RegStatus = 12'h004;
   localparam logic [RegAddrW-1:0] RegTxData = 12'h008;

   // STATUS register bit positions
   localparam int unsigned StatusRxEmpty    = 0;
   localparam int unsigned StatusRxFull     = 1;
   localparam int unsigned StatusRxOverflow = 2;
   localparam int unsigned StatusTxUnderrun = 3;
   localparam int unsigned StatusFrameErr   = 4;

   typedef enum logic {
      SpiIdle   = 1'b0,
      SpiActive = 1'b1
   } spi_dev_state_e;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO; a write is accepted when full if a read happens in the same cycle.
module prim_fifo_sync #(
   parameter int unsigned  Width = 8,
   parameter bit           Pass  = 1'b0,
   parameter int unsigned  Depth = 4,
   localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             empty, pass_through, store, pop_mem;

   // Handshake, pointer and occupancy update
   always_comb begin
      empty        = (cnt_q == '0);
      full_o       = (cnt_q == CntW'(Depth));
      wready_o     = ~full_o | rready_i;
      pass_through = Pass & empty & wvalid_i & rready_i;
      store        = wvalid_i & wready_o & ~pass_through;
      pop_mem      = rready_i & ~empty;
      rvalid_o     = ~empty | (Pass & wvalid_i);
      rdata_o      = (Pass & empty) ? wdata_i : mem_q[rptr_q];

      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (store) begin
         wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop_mem) begin
         rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      case ({store, pop_mem})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk_i) begin
      if (store) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous inputs.
module prim_flop_2sync #(
   parameter int unsigned           Width      = 1,
   parameter logic [Width-1:0]      ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] stage_q;

   // Metastability filter: two back-to-back capture stages
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q <= ResetValue;
         q_o     <= ResetValue;
      end else begin
         stage_q <= d_i;
         q_o     <= stage_q;
      end
   end

endmodule

// File: rtl/spi_device_shifter.sv
// SPI mode-0 target engine: input sync, edge detect, frame FSM, bit counter, RX/TX shift registers.
module spi_device_shifter
   import spi_pkg::*;
#(
   parameter logic [ByteW-1:0] TxDefault = 8'hFF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sck_i,
   input  logic             csn_i,
   input  logic             sdi_i,
   input  logic             tx_valid_i,
   input  logic [ByteW-1:0] tx_data_i,
   output logic             tx_take_c,
   output logic             tx_underrun_c,
   output logic             frame_err_c,
   output logic             rx_push_c,
   output logic [ByteW-1:0] rx_byte_c,
   output logic             sdo_o,
   output logic             sdo_oe_o
);

   logic [2:0]         pins_s;
   logic               sck_s, csn_s, sdi_s;
   logic               sck_dly_q, csn_dly_q;
   logic               sck_rise, sck_fall, csn_fall, csn_rise;
   spi_dev_state_e     state_q, state_d;
   logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
   logic [ByteW-1:0]   shift_rx_q, shift_rx_d;
   logic [ByteW-1:0]   shift_tx_q, shift_tx_d;
   logic [ByteW-1:0]   reload_byte;
   logic               sdo_d, sdo_oe_d;

   // CSn resets high so the synchroniser does not report a spurious select
   prim_flop_2sync #(
      .Width      (3),
      .ResetValue (3'b010)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({sck_i, csn_i, sdi_i}),
      .q_o    (pins_s)
   );

   assign sck_s    = pins_s[2];
   assign csn_s    = pins_s[1];
   assign sdi_s    = pins_s[0];
   assign sck_rise = sck_s & ~sck_dly_q;
   assign sck_fall = ~sck_s & sck_dly_q;
   assign csn_fall = ~csn_s & csn_dly_q;
   assign csn_rise = csn_s & ~csn_dly_q;

   // Frame FSM, shifting and event pulses
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_rx_d    = shift_rx_q;
      shift_tx_d    = shift_tx_q;
      tx_take_c     = 1'b0;
      tx_underrun_c = 1'b0;
      frame_err_c   = 1'b0;
      rx_push_c     = 1'b0;
      rx_byte_c     = {shift_rx_q[ByteW-2:0], sdi_s};
      reload_byte   = tx_valid_i ? tx_data_i : TxDefault;

      case (state_q)
         SpiIdle: begin
            if (csn_fall) begin
               state_d       = SpiActive;
               bit_cnt_d     = '0;
               shift_tx_d    = reload_byte;
               tx_take_c     = tx_valid_i;
               tx_underrun_c = ~tx_valid_i;
            end
         end
         SpiActive: begin
            if (csn_rise) begin
               state_d     = SpiIdle;
               frame_err_c = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
            end else if (sck_rise) begin
               shift_rx_d = rx_byte_c;
               bit_cnt_d  = bit_cnt_q + BitCntW'(1);
               rx_push_c  = (bit_cnt_q == '1);
            end else if (sck_fall) begin
               if (bit_cnt_q == '0) begin
                  shift_tx_d    = reload_byte;
                  tx_take_c     = tx_valid_i;
                  tx_underrun_c = ~tx_valid_i;
               end else begin
                  shift_tx_d = {shift_tx_q[ByteW-2:0], 1'b0};
               end
            end
         end
         default: state_d = SpiIdle;
      endcase

      sdo_oe_d = (state_d == SpiActive);
      sdo_d    = sdo_oe_d & shift_tx_d[ByteW-1];
   end

   // State, shift and registered MISO outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_dly_q  <= 1'b0;
         csn_dly_q  <= 1'b1;
         state_q    <= SpiIdle;
         bit_cnt_q  <= '0;
         shift_rx_q <= '0;
         shift_tx_q <= '0;
         sdo_o      <= 1'b0;
         sdo_oe_o   <= 1'b0;
      end else begin
         sck_dly_q  <= sck_s;
         csn_dly_q  <= csn_s;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_rx_q <= shift_rx_d;
         shift_tx_q <= shift_tx_d;
         sdo_o      <= sdo_d;
         sdo_oe_o   <= sdo_oe_d;
      end
   end

endmodule

// File: rtl/spi_device_top.sv
// SPI target peripheral: register decode, reply byte, sticky flags and RX FIFO.
module spi_device_top
   import spi_pkg::*;
#(
   parameter int unsigned      RxDepth   = 16,
   parameter logic [ByteW-1:0] TxDefault = 8'hFF
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                device_req_i,
   input  logic [31:0]         device_addr_i,
   input  logic                device_we_i,
   input  logic [3:0]          device_be_i,
   input  logic [31:0]         device_wdata_i,
   output logic                device_rvalid_o,
   output logic [31:0]         device_rdata_o,
   input  logic                sck_i,
   input  logic                csn_i,
   input  logic                sdi_i,
   output logic                sdo_o,
   output logic                sdo_oe_o,
   output logic                rx_irq_o
);

   logic [RegAddrW-1:0] bus_addr;
   logic                bus_rd, bus_wr, wr_status, wr_tx;
   logic                tx_take, underrun_set, frame_err_set, rx_push;
   logic [ByteW-1:0]    rx_byte;
   logic                fifo_wready, fifo_rvalid, fifo_full, rx_pop, ovf_set;
   logic [ByteW-1:0]    fifo_rdata;
   logic [ByteW-1:0]    tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                rx_overflow_q, rx_overflow_d;
   logic                tx_underrun_q, tx_underrun_d;
   logic                frame_err_q, frame_err_d;
   logic                rvalid_d, rx_irq_d;
   logic [BusDataW-1:0] rdata_d, status_c;
   logic                unused_bus;

   assign unused_bus = ^{device_addr_i[31:RegAddrW], device_be_i[3:1], device_wdata_i[31:ByteW]};

   spi_device_shifter #(
      .TxDefault (TxDefault)
   ) u_shifter (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .sck_i         (sck_i),
      .csn_i         (csn_i),
      .sdi_i         (sdi_i),
      .tx_valid_i    (tx_valid_q),
      .tx_data_i     (tx_data_q),
      .tx_take_c     (tx_take),
      .tx_underrun_c (underrun_set),
      .frame_err_c   (frame_err_set),
      .rx_push_c     (rx_push),
      .rx_byte_c     (rx_byte),
      .sdo_o         (sdo_o),
      .sdo_oe_o      (sdo_oe_o)
   );

   prim_fifo_sync #(
      .Width (ByteW),
      .Pass  (1'b0),
      .Depth (RxDepth)
   ) u_rx_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wvalid_i (rx_push),
      .wready_o (fifo_wready),
      .wdata_i  (rx_byte),
      .rvalid_o (fifo_rvalid),
      .rready_i (rx_pop),
      .rdata_o  (fifo_rdata),
      .full_o   (fifo_full)
   );

   // Bus decode, read mux, reply byte and sticky flag update
   always_comb begin
      bus_addr  = device_addr_i[RegAddrW-1:0];
      bus_rd    = device_req_i & ~device_we_i;
      bus_wr    = device_req_i & device_we_i & device_be_i[0];
      wr_status = bus_wr & (bus_addr == RegStatus);
      wr_tx     = bus_wr & (bus_addr == RegTxData);
      rx_pop    = bus_rd & (bus_addr == RegRxData) & fifo_rvalid;
      ovf_set   = rx_push & ~fifo_wready;

      status_c                   = '0;
      status_c[StatusRxEmpty]    = ~fifo_rvalid;
      status_c[StatusRxFull]     = fifo_full;
      status_c[StatusRxOverflow] = rx_overflow_q;
      status_c[StatusTxUnderrun] = tx_underrun_q;
      status_c[StatusFrameErr]   = frame_err_q;

      rvalid_d = device_req_i;
      rdata_d  = '0;
      if (bus_rd) begin
         case (bus_addr)
            RegRxData: rdata_d = fifo_rvalid ? BusDataW'(fifo_rdata) : '0;
            RegStatus: rdata_d = status_c;
            default:   rdata_d = '0;
         endcase
      end

      // A bus write in the reload cycle lands after the shifter consumed the old state
      tx_data_d  = wr_tx ? device_wdata_i[ByteW-1:0] : tx_data_q;
      tx_valid_d = wr_tx | (tx_valid_q & ~tx_take);

      rx_overflow_d = (rx_overflow_q & ~(wr_status & device_wdata_i[StatusRxOverflow])) | ovf_set;
      tx_underrun_d = (tx_underrun_q & ~(wr_status & device_wdata_i[StatusTxUnderrun])) | underrun_set;
      frame_err_d   = (frame_err_q & ~(wr_status & device_wdata_i[StatusFrameErr])) | frame_err_set;

      rx_irq_d = fifo_rvalid;
   end

   // Register state and bus response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         device_rvalid_o <= 1'b0;
         device_rdata_o  <= '0;
         tx_data_q       <= '0;
         tx_valid_q      <= 1'b0;
         rx_overflow_q   <= 1'b0;
         tx_underrun_q   <= 1'b0;
         frame_err_q     <= 1'b0;
         rx_irq_o        <= 1'b0;
      end else begin
         device_rvalid_o <= rvalid_d;
         device_rdata_o  <= rdata_d;
         tx_data_q       <= tx_data_d;
         tx_valid_q      <= tx_valid_d;
         rx_overflow_q   <= rx_overflow_d;
         tx_underrun_q   <= tx_underrun_d;
         frame_err_q     <= frame_err_d;
         rx_irq_o        <= rx_irq_d;
      end
   end

endmodule

// File: tb/tb_spi_device_top.sv
// Directed bench for spi_device_top: register access, SPI frames, FIFO limits, sticky flags.
module tb_spi_device_top;

   localparam int HALF  = 5;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid;
   logic [31:0] rdata;
   logic        sck = 1'b0;
   logic        csn = 1'b1;
   logic        sdi = 1'b0;
   logic        sdo, sdo_oe, irq;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_device_top #(.RxDepth(DEPTH), .TxDefault(8'hFF)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .device_req_i    (req),
      .device_addr_i   (addr),
      .device_we_i     (we),
      .device_be_i     (be),
      .device_wdata_i  (wdata),
      .device_rvalid_o (rvalid),
      .device_rdata_o  (rdata),
      .sck_i           (sck),
      .csn_i           (csn),
      .sdi_i           (sdi),
      .sdo_o           (sdo),
      .sdo_oe_o        (sdo_oe),
      .rx_irq_o        (irq)
   );

   initial begin
      #1ms;
      $display("FAIL timeout: bench did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   // All tasks start and end right after a falling clock edge.
   task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
      req = 1'b1; we = 1'b0; be = 4'hF; addr = {20'h0, a};
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1) begin
         errors++;
         $display("FAIL rd_rvalid addr=%h got=%b exp=1", a, rvalid);
      end
      d = rdata;
      req = 1'b0;
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      req = 1'b1; we = 1'b1; be = b; addr = {20'h0, a}; wdata = d;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL wr_resp addr=%h got rvalid=%b rdata=%h exp 1/0", a, rvalid, rdata);
      end
      req = 1'b0; we = 1'b0;
   endtask

   task automatic spi_bit(input logic b, output logic m);
      sdi = b;
      repeat (HALF) @(negedge clk);
      m = sdo;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(mo[i], b);
         mi[i] = b;
      end
   endtask

   task automatic cs_low();
      csn = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (HALF) @(negedge clk);
      csn = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic expect_status(input string nm, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(12'h004, d);
      checks++;
      if (d !== exp) begin
         errors++;
         $display("FAIL %s status got=%h exp=%h", nm, d, exp);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(negedge clk);
      checks++;
      if ({sdo, sdo_oe, rvalid, irq} !== 4'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outs got sdo=%b oe=%b rvalid=%b irq=%b rdata=%h exp all 0",
                  sdo, sdo_oe, rvalid, irq, rdata);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(12'h004, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL reset_status got=%h exp=00000001", d);
      end
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rvalid_drop got=%b exp=0", rvalid);
      end
      bus_read(12'h100, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_read got=%h exp=0", d);
      end
   endtask

   task automatic test_basic();
      logic [7:0]  mi;
      logic [31:0] d;
      bus_write(12'h008, 32'h0000_003C, 4'h1);
      cs_low();
      checks++;
      if (sdo_oe !== 1'b1) begin
         errors++;
         $display("FAIL oe_active got=%b exp=1", sdo_oe);
      end
      spi_byte(8'hA5, mi);
      cs_high();
      checks++;
      if (mi !== 8'h3C) begin
         errors++;
         $display("FAIL basic_miso got=%h exp=3c", mi);
      end
      checks++;
      if (sdo_oe !== 1'b0 || irq !== 1'b1) begin
         errors++;
         $display("FAIL basic_oe_irq got oe=%b irq=%b exp 0/1", sdo_oe, irq);
      end
      expect_status("basic_after_frame", 32'h08);
      bus_read(12'h000, d);
      checks++;
      if (d !== 32'hA5) begin
         errors++;
         $display("FAIL basic_rx got=%h exp=a5", d);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL basic_irq_clear got=%b exp=0", irq);
      end
      expect_status("basic_after_read", 32'h09);
   endtask

   task automatic test_underrun();
      logic [7:0]  mi;
      logic [31:0] d;
      logic [7:0]  vec [3];
      vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
      bus_write(12'h004, 32'h08, 4'h0);
      expect_status("w1c_be0_ignored", 32'h09);
      bus_write(12'h004, 32'h08, 4'h1);
      expect_status("w1c_underrun", 32'h01);
      cs_low();
      for (int i = 0; i < 3; i++) begin
         spi_byte(vec[i], mi);
         checks++;
         if (mi !== 8'hFF) begin
            errors++;
            $display("FAIL underrun_miso byte=%0d got=%h exp=ff", i, mi);
         end
      end
      cs_high();
      expect_status("underrun_set", 32'h08);
      for (int i = 0; i < 3; i++) begin
         bus_read(12'h000, d);
         checks++;
         if (d !== {24'h0, vec[i]}) begin
            errors++;
            $display("FAIL underrun_rx idx=%0d got=%h exp=%h", i, d, vec[i]);
         end
      end
      bus_write(12'h004, 32'h08, 4'h1);
      expect_status("underrun_cleared", 32'h01);
   endtask

   task automatic test_overflow();
      logic [7:0]  mi;
      logic [31:0] d;
      cs_low();
      for (int i = 0; i <= DEPTH; i++) spi_byte(8'h40 + 8'(i), mi);
      cs_high();
      expect_status("overflow_full", 32'h0E);
      for (int i = 0; i < DEPTH; i++) begin
         bus_read(12'h000, d);
         checks++;
         if (d !== {24'h0, 8'h40 + 8'(i)}) begin
            errors++;
            $display("FAIL overflow_order idx=%0d got=%h exp=%h", i, d, 8'h40 + 8'(i));
         end
      end
      bus_read(12'h000, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL empty_read got=%h exp=0", d);
      end
      expect_status("overflow_drained", 32'h0D);
      bus_write(12'h004, 32'h1C, 4'h1);
      expect_status("overflow_cleared", 32'h01);
   endtask

   task automatic test_frame_err();
      logic        b;
      logic [7:0]  mi;
      logic [31:0] d;
      bus_write(12'h008, 32'h5A, 4'h1);
      cs_low();
      for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
      cs_high();
      expect_status("frame_err_set", 32'h11);
      bus_write(12'h008, 32'h12, 4'h1);
      bus_write(12'h008, 32'h77, 4'h1);
      cs_low();
      spi_byte(8'h81, mi);
      cs_high();
      checks++;
      if (mi !== 8'h77) begin
         errors++;
         $display("FAIL tx_overwrite got=%h exp=77", mi);
      end
      expect_status("after_recovery", 32'h18);
      bus_read(12'h000, d);
      checks++;
      if (d !== 32'h81) begin
         errors++;
         $display("FAIL recovery_rx got=%h exp=81", d);
      end
      bus_write(12'h004, 32'h1C, 4'h1);
      expect_status("frame_err_cleared", 32'h01);
   endtask

   task automatic test_push_pop_full();
      logic        b;
      logic [7:0]  mi;
      logic [31:0] d;
      logic [7:0]  last;
      last = 8'hEE;
      cs_low();
      for (int i = 0; i < DEPTH; i++) spi_byte(8'h60 + 8'(i), mi);
      // Final byte: pop RX_DATA in the exact cycle the shifter pushes
      for (int i = 7; i >= 1; i--) spi_bit(last[i], b);
      sdi = last[0];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(12'h000, d);
      checks++;
      if (d !== 32'h60) begin
         errors++;
         $display("FAIL coincident_pop got=%h exp=60", d);
      end
      repeat (HALF - 3) @(negedge clk);
      sck = 1'b0;
      cs_high();
      expect_status("push_pop_full", 32'h0A);
      for (int i = 1; i <= DEPTH; i++) begin
         bus_read(12'h000, d);
         checks++;
         if (d !== ((i == DEPTH) ? 32'hEE : {24'h0, 8'h60 + 8'(i)})) begin
            errors++;
            $display("FAIL push_pop_order idx=%0d got=%h", i, d);
         end
      end
      expect_status("push_pop_drained", 32'h09);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_overflow();
      test_frame_err();
      test_push_pop_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
